gate_exerciser: RTL
===================

Name: gate_exerciser

Overview:
- Self-checking driver/observer for a 2-input, 1-output combinational gate under test (DUT).
- Drives the DUT inputs through all four input vectors in a fixed order, waits a settle interval per vector, and samples the DUT output.
- Compares each sample against the truth table chosen by gate_sel, then reports the error count, a per-vector fail mask and pass/done.
- Sits beside gate-level primitives as the synthesizable, clocked counterpart that exercises and checks them on-chip.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before dut_c is sampled; legal range 1..15.
- ERR_W, 3, width of err_count; the count saturates at 2^ERR_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a test run; honoured only in IDLE.
- gate_sel  input  3  expected gate function; latched when start is accepted.
- dut_a  output  1  registered DUT input A.
- dut_b  output  1  registered DUT input B.
- dut_c  input  1  DUT output being checked.
- busy  output  1  high while vectors are being applied.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 if the last completed run had zero mismatches; held until the next accepted start.
- err_count  output  ERR_W  mismatch count for the current or last run (saturating).
- fail_mask  output  4  bit k set if vector k = {a,b} mismatched.

Behaviour:
- Reset (async, active-high): state=IDLE; dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0. Asserting reset mid-run aborts the run immediately; no done pulse is produced.
- Truth table: tt[3:0] is indexed by {a,b}; expected output = tt[{dut_a,dut_b}].
  - gate_sel 0 AND = 4'b1000
  - gate_sel 1 OR = 4'b1110
  - gate_sel 2 XOR = 4'b0110
  - gate_sel 3 NAND = 4'b0111
  - gate_sel 4 NOR = 4'b0001
  - gate_sel 5 XNOR = 4'b1001
  - gate_sel 6 BUF_A = 4'b1100
  - gate_sel 7 BUF_B = 4'b1010
- State IDLE -> RUN, at the edge E0 where start=1:
  - latch gate_sel;
  - clear err_count and fail_mask; pass=0;
  - busy=1; vector index v=0; {dut_a,dut_b}=00;
  - settle counter loaded.
- State RUN:
  - Each vector is held exactly SETTLE_CYCLES cycles.
  - At edge E0+SETTLE_CYCLES*(v+1), dut_c is sampled and compared with tt[v].
  - On mismatch: fail_mask[v]<=1, and err_count increments unless already saturated.
  - At that same edge, if v<3: v<=v+1 and {dut_a,dut_b}<=v+1 (order 00,01,10,11).
  - If v==3: go to DONE.
- RUN -> DONE, at edge E0+4*SETTLE_CYCLES:
  - busy=0; done=1; {dut_a,dut_b}=00;
  - pass = 1 if there were no mismatches including the final sample, else 0.
- State DONE lasts one cycle; next edge: done=0, state=IDLE.
- Run length: busy is high for exactly 4*SETTLE_CYCLES cycles. The next start can be accepted no earlier than one cycle after done.
- start while in RUN or DONE is ignored (no restart, no effect).
- gate_sel changes after acceptance have no effect on the current run.
- err_count, fail_mask and pass hold their values in IDLE until the next accepted start.
- dut_c is sampled only at the comparison edges; its value at any other time is don't-care.

Test Plan:
- Correct AND DUT, gate_sel=0, SETTLE_CYCLES=2, start at E0 -> vectors 00/01/10/11 at E0/E2/E4/E6; done pulse after E8; pass=1, err_count=0, fail_mask=0000; busy high for 8 cycles.
- dut_c stuck-at-0, gate_sel=0 (AND) -> err_count=1, fail_mask=1000, pass=0.
- OR DUT, gate_sel=0 (AND expected) -> mismatches on 01 and 10: err_count=2, fail_mask=0110, pass=0.
- dut_c stuck-at-1, gate_sel=4 (NOR) -> err_count=3, fail_mask=1110. Same stimulus with ERR_W=1 -> err_count saturates at 1; fail_mask still 1110.
- Pulse start again at E3 mid-run and change gate_sel to 1 -> run unchanged, done still after E8, results match the AND check; second start one cycle after done -> new run, err_count/fail_mask cleared at acceptance.
- Assert rst at E5 mid-run -> all outputs return to reset values asynchronously, no done pulse; start after release -> full clean run.

Source files
------------

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - clocked driver/checker for a 2-input, 1-output gate.
// Steps {a,b} through 00,01,10,11, samples dut_c after each settle window, and compares it with the gate_sel truth table.
module gate_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_mask
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state_q;
    logic [2:0]       gsel_q;
    logic [1:0]       vec_q;
    logic [3:0]       cnt_q;
    logic             a_q, b_q, busy_q, done_q, pass_q;
    logic [ERR_W-1:0] err_q;
    logic [3:0]       mask_q;

    logic [3:0]       tt_d;
    logic             mismatch_d;
    logic [ERR_W-1:0] err_d;

    always_comb begin
        tt_d = 4'b0000;
        case (gsel_q)
            3'd0: tt_d = 4'b1000;
            3'd1: tt_d = 4'b1110;
            3'd2: tt_d = 4'b0110;
            3'd3: tt_d = 4'b0111;
            3'd4: tt_d = 4'b0001;
            3'd5: tt_d = 4'b1001;
            3'd6: tt_d = 4'b1100;
            default: tt_d = 4'b1010;
        endcase
        mismatch_d = (dut_c != tt_d[vec_q]);
        err_d      = (mismatch_d && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gsel_q  <= 3'd0;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        gsel_q  <= gate_sel;
                        vec_q   <= 2'd0;
                        cnt_q   <= SETTLE_LOAD;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        mask_q  <= 4'd0;
                    end
                end
                RUN: begin
                    if (cnt_q == 4'd0) begin
                        err_q <= err_d;
                        if (mismatch_d) mask_q[vec_q] <= 1'b1;
                        if (vec_q == 2'd3) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            // Final sample has not reached mask_q yet, so fold it in here.
                            pass_q  <= (mask_q == 4'd0) && !mismatch_d;
                        end else begin
                            vec_q <= vec_q + 2'd1;
                            {a_q, b_q} <= vec_q + 2'd1;
                            cnt_q <= SETTLE_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_a     = a_q;
    assign dut_b     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule
